// File: rtl/mem_bus_unit_pkg.sv
// Control-word bit positions decoded by the memory bus unit, plus shared widths.
package mem_bus_unit_pkg;

  localparam int unsigned CsWidth  = 24;
  localparam int unsigned CsWmfc   = 8;
  localparam int unsigned CsRnw    = 9;
  localparam int unsigned CsMarIn  = 18;
  localparam int unsigned CsMbrOut = 19;

  localparam int unsigned CtrW = 8;

endpackage

// File: rtl/mem_bus_unit_if.sv
// External memory port: request/acknowledge handshake with address and data.
interface mem_bus_unit_if #(
  parameter int unsigned DW = 8
) ();

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_bus_unit_timeout_ctr.sv
// Saturating cycle counter for the memory request; flags the last permitted cycle.
module mem_timeout_ctr
  import mem_bus_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CtrW-1:0] Max  = CtrW'(TIMEOUT);
  localparam logic [CtrW-1:0] Last = CtrW'(TIMEOUT - 1);

  logic [CtrW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < Max)) begin
      cnt_d = cnt_q + CtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == Last);

endmodule

// File: rtl/mem_bus_unit.sv
// Memory-side responder for the CU: holds MAR/MBR and runs the req/ack memory handshake,
// returning a one-cycle MFC when the access completes or times out.
module mem_bus_unit
  import mem_bus_unit_pkg::*;
#(
  parameter int unsigned SZ      = CsWidth,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [SZ-1:0]  CS_bus,
  input  logic [DW-1:0]  bus_in,
  output logic [DW-1:0]  bus_out,
  output logic           bus_oe,
  output logic           MFC,
  output logic           err,
  mem_bus_unit_if.master mem
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e        state_d, state_q;
  logic [DW-1:0] mar_d, mar_q, mbr_d, mbr_q;
  logic          we_d, we_q, req_d, req_q, mfc_d, mfc_q, err_d, err_q;
  logic          armed_d, armed_q;
  logic          ctr_clr, ctr_en, ctr_expire;
  logic          wmfc, rnw, mar_in, unused_cs;

  assign wmfc      = CS_bus[CsWmfc];
  assign rnw       = CS_bus[CsRnw];
  assign mar_in    = CS_bus[CsMarIn];
  assign unused_cs = ^CS_bus;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (ctr_clr),
    .en_i    (ctr_en),
    .expire_o(ctr_expire)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    we_d    = we_q;
    req_d   = req_q;
    mfc_d   = 1'b0;
    err_d   = err_q;
    // WMFC lingers one cycle past MFC; only a low sample re-arms the next request.
    armed_d = armed_q | ~wmfc;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mar_in) mar_d = bus_in;
        if (wmfc && armed_q) begin
          we_d    = ~rnw;
          if (!rnw) mbr_d = bus_in;
          ctr_clr = 1'b1;
          req_d   = 1'b1;
          armed_d = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        ctr_en = 1'b1;
        if (mem.mem_ack) begin
          if (!we_q) mbr_d = mem.mem_rdata;
          req_d   = 1'b0;
          mfc_d   = 1'b1;
          state_d = StDone;
        end else if (ctr_expire) begin
          if (!we_q) mbr_d = {DW{1'b1}};
          err_d   = 1'b1;
          req_d   = 1'b0;
          mfc_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mbr_q   <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      we_q    <= we_d;
      req_q   <= req_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign bus_out       = mbr_q;
  assign bus_oe        = CS_bus[CsMbrOut];
  assign MFC           = mfc_q;
  assign err           = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mbr_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Self-checking bench for mem_bus_unit: directed scenarios plus randomized transactions
// checked against a transaction-level model of MAR, MBR and the sticky error flag.
module tb_mem_bus_unit;
  import mem_bus_unit_pkg::*;

  localparam int unsigned SZ      = 24;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SZ-1:0] cs_bus, junk;
  logic [DW-1:0] bus_in, bus_out;
  logic          bus_oe, mfc, err;
  logic          wmfc, rnw, mar_in, mbr_out;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] m_mar, m_mbr;
  logic       m_err;

  mem_bus_unit_if #(.DW(DW)) mem ();

  mem_bus_unit #(.SZ(SZ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .CS_bus (cs_bus),
    .bus_in (bus_in),
    .bus_out(bus_out),
    .bus_oe (bus_oe),
    .MFC    (mfc),
    .err    (err),
    .mem    (mem)
  );

  always #5 clk = ~clk;

  // Unrelated control bits carry random junk to exercise the decode.
  always_comb begin
    cs_bus           = junk;
    cs_bus[CsWmfc]   = wmfc;
    cs_bus[CsRnw]    = rnw;
    cs_bus[CsMarIn]  = mar_in;
    cs_bus[CsMbrOut] = mbr_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    junk = SZ'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wmfc = 1'b0; mar_in = 1'b0; mbr_out = 1'b1; mem.mem_ack = 1'b0;
    #2;
    n_total++; if ({mem.mem_req, mem.mem_we, mfc, err} !== 4'b0000) $display("FAIL reset_ctl: got %b want 0000", {mem.mem_req, mem.mem_we, mfc, err}); else n_pass++;
    n_total++; if ({mem.mem_addr, mem.mem_wdata, bus_out} !== 24'h0) $display("FAIL reset_regs: got %h want 000000", {mem.mem_addr, mem.mem_wdata, bus_out}); else n_pass++;
    n_total++; if (bus_oe !== 1'b1) $display("FAIL reset_oe: got %b want 1", bus_oe); else n_pass++;
    tick(); tick();
    rst_n = 1'b1; mbr_out = 1'b0;
    tick();
    m_mar = 8'h00; m_mbr = 8'h00; m_err = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    int pulses;
    pulses = 0;
    mar_in = 1'b1; bus_in = 8'h5A; tick();
    mar_in = 1'b0; wmfc = 1'b1; rnw = 1'b1; tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({mem.mem_req, mfc} !== 2'b00) $display("FAIL rst_mid_req: got %b want 00", {mem.mem_req, mfc}); else n_pass++;
    n_total++; if (mem.mem_addr !== 8'h00) $display("FAIL rst_mid_mar: got %h want 00", mem.mem_addr); else n_pass++;
    mem.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (mfc) pulses++; end
    mem.mem_ack = 1'b0; wmfc = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (mfc) pulses++; end
    n_total++; if (pulses !== 0) $display("FAIL rst_mid_mfc: got %0d pulses want 0", pulses); else n_pass++;
    m_mar = 8'h00; m_mbr = 8'h00; m_err = 1'b0;
  endtask

  // One full CU-style access; ack_at is the REQ cycle (0-based) that sees mem_ack, -1 for none.
  task automatic do_txn(input logic [7:0] addr, input logic is_read, input logic [7:0] wdata,
                        input int ack_at, input logic [7:0] rdata, input logic poke);
    int cycles;
    logic seen, acked;
    logic [7:0] old_mbr, shown;
    old_mbr = m_mbr;
    mar_in = 1'b1; bus_in = addr; tick();
    mar_in = 1'b0; wmfc = 1'b1; rnw = is_read; bus_in = wdata; tick();
    m_mar = addr;
    shown = is_read ? old_mbr : wdata;
    acked = (ack_at >= 0) && (ack_at < int'(TIMEOUT));
    seen = 1'b0; cycles = 0;
    if (poke) begin mar_in = 1'b1; bus_in = 8'hEE; end
    for (int k = 0; k < int'(TIMEOUT) + 4 && !seen; k++) begin
      if (!poke) bus_in = 8'($urandom);
      mbr_out = 1'($urandom);
      mem.mem_ack = (k == ack_at);
      mem.mem_rdata = (k == ack_at) ? rdata : 8'($urandom);
      #1;
      n_total++; if ({mem.mem_req, mem.mem_we, mem.mem_addr} !== {1'b1, ~is_read, addr}) $display("FAIL req_hold: got %b/%b/%h want 1/%b/%h", mem.mem_req, mem.mem_we, mem.mem_addr, ~is_read, addr); else n_pass++;
      if (!is_read) begin
        n_total++; if (mem.mem_wdata !== wdata) $display("FAIL wdata_hold: got %h want %h", mem.mem_wdata, wdata); else n_pass++;
      end
      n_total++; if (bus_oe !== mbr_out) $display("FAIL oe_req: got %b want %b", bus_oe, mbr_out); else n_pass++;
      if (mbr_out) begin
        n_total++; if (bus_out !== shown) $display("FAIL mbr_during_req: got %h want %h", bus_out, shown); else n_pass++;
      end
      tick();
      mem.mem_ack = 1'b0;
      cycles++;
      if (mfc) seen = 1'b1;
    end
    mar_in = 1'b0; mbr_out = 1'b0;
    m_mbr = !is_read ? wdata : (acked ? rdata : 8'hFF);
    if (!acked) m_err = 1'b1;
    n_total++; if (seen !== 1'b1) $display("FAIL mfc_seen: got %b want 1", seen); else n_pass++;
    n_total++; if (cycles !== (acked ? ack_at + 1 : int'(TIMEOUT))) $display("FAIL latency: got %0d want %0d", cycles, acked ? ack_at + 1 : int'(TIMEOUT)); else n_pass++;
    n_total++; if ({mem.mem_req, err, mem.mem_addr} !== {1'b0, m_err, addr}) $display("FAIL done_state: got %b/%b/%h want 0/%b/%h", mem.mem_req, err, mem.mem_addr, m_err, addr); else n_pass++;
    // WMFC still high after MFC, with stray acks: no second request, no second pulse.
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'($urandom);
    tick();
    n_total++; if ({mfc, mem.mem_req} !== 2'b00) $display("FAIL post_done1: got %b want 00", {mfc, mem.mem_req}); else n_pass++;
    tick();
    n_total++; if ({mfc, mem.mem_req} !== 2'b00) $display("FAIL no_rearm: got %b want 00", {mfc, mem.mem_req}); else n_pass++;
    mem.mem_ack = 1'b0; wmfc = 1'b0; rnw = 1'b1;
    tick();
    mbr_out = 1'b1; #1;
    n_total++; if ({bus_oe, bus_out, mem.mem_wdata} !== {1'b1, m_mbr, m_mbr}) $display("FAIL mbr_final: got %b/%h/%h want 1/%h/%h", bus_oe, bus_out, mem.mem_wdata, m_mbr, m_mbr); else n_pass++;
    n_total++; if ({mem.mem_addr, err} !== {m_mar, m_err}) $display("FAIL idle_state: got %h/%b want %h/%b", mem.mem_addr, err, m_mar, m_err); else n_pass++;
    mbr_out = 1'b0;
  endtask

  task automatic test_read();
    do_txn(8'h3C, 1'b1, 8'h00, 0, 8'hA5, 1'b0);
  endtask

  task automatic test_write();
    do_txn(8'h10, 1'b0, 8'h77, 3, 8'h00, 1'b0);
  endtask

  task automatic test_mar_hold();
    do_txn(8'h42, 1'b1, 8'h00, 5, 8'h9E, 1'b1);
  endtask

  task automatic test_timeout();
    do_txn(8'h81, 1'b1, 8'h00, -1, 8'h00, 1'b0);
    tick(); tick();
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    mar_in = 1'b1; wmfc = 1'b1; rnw = 1'b1; bus_in = 8'hC3; tick();
    mar_in = 1'b0;
    n_total++; if ({mem.mem_req, mem.mem_addr} !== {1'b1, 8'hC3}) $display("FAIL b2b_req1: got %b/%h want 1/c3", mem.mem_req, mem.mem_addr); else n_pass++;
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'h11; tick();
    if (mfc) pulses++;
    mem.mem_rdata = 8'h99; tick();
    if (mfc) pulses++;
    wmfc = 1'b0; tick();
    if (mfc) pulses++;
    mem.mem_ack = 1'b0; mbr_out = 1'b1; #1;
    n_total++; if ({mem.mem_req, bus_out} !== {1'b0, 8'h11}) $display("FAIL b2b_idle_ack: got %b/%h want 0/11", mem.mem_req, bus_out); else n_pass++;
    mbr_out = 1'b0; mar_in = 1'b1; wmfc = 1'b1; bus_in = 8'h3D; tick();
    mar_in = 1'b0;
    n_total++; if ({mem.mem_req, mem.mem_addr} !== {1'b1, 8'h3D}) $display("FAIL b2b_req2: got %b/%h want 1/3d", mem.mem_req, mem.mem_addr); else n_pass++;
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'h22; tick();
    mem.mem_ack = 1'b0;
    if (mfc) pulses++;
    tick();
    if (mfc) pulses++;
    wmfc = 1'b0; tick();
    n_total++; if (pulses !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else n_pass++;
    mbr_out = 1'b1; #1;
    n_total++; if (bus_out !== 8'h22) $display("FAIL b2b_mbr: got %h want 22", bus_out); else n_pass++;
    mbr_out = 1'b0;
    m_mar = 8'h3D; m_mbr = 8'h22;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_txn(8'($urandom), 1'($urandom), 8'($urandom),
             int'($urandom_range(0, TIMEOUT + 2)), 8'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    junk = '0; wmfc = 1'b0; rnw = 1'b1; mar_in = 1'b0; mbr_out = 1'b0; bus_in = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    m_mar = 8'h00; m_mbr = 8'h00; m_err = 1'b0;
    test_reset();
    test_reset_mid_req();
    test_read();
    test_write();
    test_mar_hold();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
